// File: rtl/arquitetura_timer_mc.sv
// arquitetura_timer_mc: N_CH-channel Avalon-MM interval timer, shared irq.
// Optional per-channel prescaler enabled by defining TIMER_PRESCALER_EN.
module arquitetura_timer_mc #(
    parameter int N_CH         = 2,
    parameter int COUNTER_W    = 32,
    parameter int PERIOD_RESET = 24
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [3+$clog2(N_CH)-1:0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [15:0]               writedata,
    output logic [15:0]               readdata,
    output logic                      irq
);
    localparam int AW = 3 + $clog2(N_CH);
    localparam int HW = COUNTER_W - 16;
    localparam logic [COUNTER_W-1:0] P_RST = COUNTER_W'(PERIOD_RESET);
    localparam logic [COUNTER_W-1:0] ONE   = COUNTER_W'(1);

    logic            wr_en;
    logic            rd_en;
    logic [2:0]      reg_sel;
    logic [AW:0]     addr_ext;
    logic [7:0]      ch_idx;
    logic [N_CH-1:0] ch_irq;
    logic [15:0]     ch_rdata [N_CH];
    logic [15:0]     rd_mux;

    assign wr_en    = chipselect & ~write_n;
    assign rd_en    = chipselect & write_n;
    assign reg_sel  = address[2:0];
    assign addr_ext = {1'b0, address};
    assign ch_idx   = 8'(addr_ext >> 3);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic                 sel;
        logic                 start_wr;
        logic                 stop_wr;
        logic                 tick;
        logic                 tevent;
        logic                 running;
        logic                 to;
        logic                 force_reload;
        logic                 prev_nz;
        logic [3:0]           ctrl;
        logic [COUNTER_W-1:0] cnt;
        logic [COUNTER_W-1:0] period;
        logic [COUNTER_W-1:0] snap;
        logic [COUNTER_W-1:0] cnt_next;
        logic [15:0]          prescale_rd;
        logic [15:0]          rdata;

        assign sel      = wr_en && (ch_idx == 8'(i));
        assign start_wr = sel && (reg_sel == 3'd1) && writedata[2];
        assign stop_wr  = sel && (reg_sel == 3'd1) && writedata[3]
                          && !writedata[2];
        assign cnt_next = (cnt == '0) ? period : cnt - ONE;
        assign tevent   = (cnt == '0) && prev_nz;
        assign ch_irq[i] = to & ctrl[0];

`ifdef TIMER_PRESCALER_EN
        logic [15:0] prescale;
        logic [15:0] pcount;

        assign tick        = (pcount == 16'd0);
        assign prescale_rd = prescale;

        // Prescaler: one tick each time pcount wraps through 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                prescale <= 16'd0;
                pcount   <= 16'd0;
            end else begin
                if (sel && reg_sel == 3'd6)
                    prescale <= writedata;
                if (start_wr || force_reload)
                    pcount <= 16'd0;
                else if (running)
                    pcount <= tick ? prescale : pcount - 16'd1;
            end
        end
`else
        assign tick        = 1'b1;
        assign prescale_rd = 16'd0;
`endif

        // Channel registers, counter, run state and timeout flag.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt          <= P_RST;
                period       <= P_RST;
                snap         <= '0;
                ctrl         <= 4'd0;
                running      <= 1'b0;
                to           <= 1'b0;
                force_reload <= 1'b0;
                prev_nz      <= 1'b0;
            end else begin
                prev_nz      <= (cnt != '0);
                force_reload <= sel && (reg_sel == 3'd2 || reg_sel == 3'd3);
                if (sel && reg_sel == 3'd0)
                    to <= 1'b0;
                else if (tevent)
                    to <= 1'b1;
                if (sel && reg_sel == 3'd1)
                    ctrl <= writedata[3:0];
                if (sel && reg_sel == 3'd2)
                    period[15:0] <= writedata;
                if (sel && reg_sel == 3'd3)
                    period[COUNTER_W-1:16] <= writedata[HW-1:0];
                if (sel && (reg_sel == 3'd4 || reg_sel == 3'd5))
                    snap <= cnt;
                if (force_reload) begin
                    cnt     <= period;
                    running <= 1'b0;
                end else if (running && tick) begin
                    cnt <= cnt_next;
                    if (!ctrl[1] && cnt_next == '0)
                        running <= 1'b0;
                end
                if (start_wr)
                    running <= 1'b1;
                else if (stop_wr)
                    running <= 1'b0;
            end
        end

        // Per-channel register read view.
        always_comb begin
            rdata = 16'd0;
            case (reg_sel)
                3'd0: rdata = {14'd0, running, to};
                3'd1: rdata = {12'd0, ctrl};
                3'd2: rdata = period[15:0];
                3'd3: rdata = 16'(period[COUNTER_W-1:16]);
                3'd4: rdata = snap[15:0];
                3'd5: rdata = 16'(snap[COUNTER_W-1:16]);
                3'd6: rdata = prescale_rd;
                default: rdata = 16'(ch_irq);
            endcase
        end

        assign ch_rdata[i] = rdata;
    end

    // Channel select; channel numbers past N_CH read as 0.
    always_comb begin
        rd_mux = 16'd0;
        for (int k = 0; k < N_CH; k++)
            if (ch_idx == 8'(k))
                rd_mux = ch_rdata[k];
    end

    // Registered read data, one cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= 16'd0;
        else if (rd_en)
            readdata <= rd_mux;
    end

    assign irq = |ch_irq;

endmodule

// File: tb/tb_arquitetura_timer_mc.sv
// tb_arquitetura_timer_mc: scoreboard bench with reference timer model.
// Reads are queued at issue; a monitor checks readdata one cycle later.
module tb_arquitetura_timer_mc;
    localparam int NCH  = 2;
    localparam int CW   = 32;
    localparam int PRST = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit last_irq;
    bit rv;
    logic [15:0] expq[$];

    longint m_cnt[NCH], m_per[NCH], m_snap[NCH];
    int m_ctl[NCH], m_pre[NCH], m_pc[NCH];
    bit m_run[NCH], m_to[NCH], m_nz[NCH], m_rl[NCH];

    always #5 clk = ~clk;

    arquitetura_timer_mc #(
        .N_CH(NCH), .COUNTER_W(CW), .PERIOD_RESET(PRST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = PRST; m_per[c] = PRST; m_snap[c] = 0;
            m_ctl[c] = 0; m_pre[c] = 0; m_pc[c] = 0;
            m_run[c] = 0; m_to[c] = 0; m_nz[c] = 0; m_rl[c] = 0;
        end
    endfunction

    function automatic bit m_irq(input int c);
        return m_to[c] && m_ctl[c][0];
    endfunction

    function automatic bit m_irq_any();
        bit v = 0;
        for (int c = 0; c < NCH; c++) v |= m_irq(c);
        return v;
    endfunction

    function automatic logic [15:0] m_read(input int a);
        int c = a >> 3;
        int r = a & 7;
        logic [15:0] v = 16'd0;
        case (r)
            0: v = {14'd0, m_run[c], m_to[c]};
            1: v = 16'(m_ctl[c] & 15);
            2: v = 16'(m_per[c]);
            3: v = 16'(m_per[c] >> 16);
            4: v = 16'(m_snap[c]);
            5: v = 16'(m_snap[c] >> 16);
            6: begin
`ifdef TIMER_PRESCALER_EN
                v = 16'(m_pre[c]);
`endif
            end
            default: for (int i = 0; i < NCH; i++) v[i] = m_irq(i);
        endcase
        return v;
    endfunction

    // One clock edge of the timer as described by its rules.
    function automatic void model_step(input bit wr, input int a, input int d);
        int cs = a >> 3;
        int r = a & 7;
        for (int c = 0; c < NCH; c++) begin
            bit mine = wr && (cs == c);
            bit start = mine && r == 1 && d[2];
            bit stop = mine && r == 1 && d[3] && !d[2];
            bit fired = (m_cnt[c] == 0) && m_nz[c];
            bit tick = 1;
            longint cnt0 = m_cnt[c];
`ifdef TIMER_PRESCALER_EN
            tick = (m_pc[c] == 0);
            if (start || m_rl[c]) m_pc[c] = 0;
            else if (m_run[c]) m_pc[c] = tick ? m_pre[c] : m_pc[c] - 1;
`endif
            if (m_rl[c]) begin
                m_cnt[c] = m_per[c];
                m_run[c] = 0;
            end else if (m_run[c] && tick) begin
                m_cnt[c] = (cnt0 == 0) ? m_per[c] : cnt0 - 1;
                if (!m_ctl[c][1] && m_cnt[c] == 0) m_run[c] = 0;
            end
            if (start) m_run[c] = 1;
            else if (stop) m_run[c] = 0;
            m_nz[c] = (cnt0 != 0);
            if (mine && r == 0) m_to[c] = 0;
            else if (fired) m_to[c] = 1;
            m_rl[c] = mine && (r == 2 || r == 3);
            if (mine) begin
                case (r)
                    1: m_ctl[c] = d & 15;
                    2: m_per[c] = (m_per[c] & 64'hFFFF0000) | (d & 'hFFFF);
                    3: m_per[c] = (m_per[c] & 64'hFFFF) | (longint'(d & 'hFFFF) << 16);
                    4, 5: m_snap[c] = cnt0;
                    6: m_pre[c] = d & 'hFFFF;
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic check(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    task automatic bus(input bit cs, input bit wr, input int a, input int d,
                       input bit use_k, input logic [15:0] k);
        @(negedge clk);
        cyc++;
        total++;
        if (irq !== m_irq_any()) begin
            bad++;
            $display("FAIL irq cyc=%0d got=%b want=%b", cyc, irq, m_irq_any());
        end
        last_irq = irq;
        chipselect = cs;
        write_n = !wr;
        address = a[3:0];
        writedata = d[15:0];
        if (cs && !wr) expq.push_back(use_k ? k : m_read(a));
        @(posedge clk);
        model_step(cs && wr, a, d);
    endtask

    task automatic idle();
        bus(0, 0, 0, 0, 0, 16'd0);
    endtask

    task automatic wr(input int a, input int d);
        bus(1, 1, a, d, 0, 16'd0);
    endtask

    task automatic rd(input int a);
        bus(1, 0, a, 0, 0, 16'd0);
    endtask

    task automatic rdk(input int a, input logic [15:0] k);
        bus(1, 0, a, 0, 1, k);
    endtask

    task automatic wait_irq(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            idle();
            if (last_irq) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("irq_wait_timeout", 0, 1);
    endtask

    // Monitor: every read presents data the cycle after it was issued.
    always @(posedge clk) rv <= chipselect && write_n && reset_n;

    always @(negedge clk) begin
        if (rv) begin
            logic [15:0] e;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got=%h", readdata);
            end else begin
                e = expq.pop_front();
                if (readdata !== e) begin
                    bad++;
                    $display("FAIL rd cyc=%0d got=%h want=%h", cyc, readdata, e);
                end
            end
        end
    end

    initial begin
        int r1, r2, n, a, op;
        model_reset();
        repeat (3) @(negedge clk);
        check("irq_reset", int'(irq), 0);
        reset_n = 1'b1;
        @(posedge clk);
        model_step(0, 0, 0);

        rdk(0, 16'h0000);
        rdk(1, 16'h0000);
        rdk(2, 16'h0018);
        rdk(3, 16'h0000);

        // ch1 continuous, period 9
        wr(10, 9);
        wr(11, 0);
        wr(9, 7);
        wait_irq(40, r1);
        rdk(15, 16'h0002);
        wr(8, 0);
        idle();
        check("irq_clear", int'(last_irq), 0);
        wait_irq(40, r2);
        check("cont_interval", r2 - r1, 10);

        // clear on the exact cycle of the next zero entry
        wr(8, 0);
        while (cyc < r2 + 8) idle();
        wr(8, 0);
        idle();
        check("clear_wins", int'(last_irq), 0);
        rdk(8, 16'h0002);

        // period write while running
        wr(10, 100);
        idle();
        wr(12, 0);
        rdk(12, 16'd100);
        rdk(13, 16'd0);
        rd(8);
        wr(9, 8);
        wr(8, 0);

        // ch0 one-shot
        wr(2, 5);
        wr(3, 0);
        wr(1, 5);
        wait_irq(40, r1);
        wr(0, 0);
        n = 0;
        repeat (30) begin
            idle();
            n += int'(last_irq);
        end
        check("oneshot_once", n, 0);
        rdk(0, 16'h0000);
        wr(4, 0);
        rdk(4, 16'h0000);

        // snapshot of a wide counter and full-width period_h
        wr(3, 1);
        wr(2, 'h2345);
        idle();
        idle();
        wr(4, 0);
        rdk(4, 16'h2345);
        rdk(5, 16'h0001);
        wr(3, 'hFFFF);
        rdk(3, 16'hFFFF);

        // prescaler register and count rate
        wr(6, 3);
`ifdef TIMER_PRESCALER_EN
        rdk(6, 16'd3);
`else
        rdk(6, 16'd0);
`endif
        wr(3, 0);
        wr(2, 4);
        wr(1, 7);
        wait_irq(60, r1);
        wr(0, 0);
        wait_irq(60, r2);
`ifdef TIMER_PRESCALER_EN
        check("rate", r2 - r1, 20);
`else
        check("rate", r2 - r1, 5);
`endif
        wr(1, 8);
        wr(0, 0);
        wr(6, 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            if (op == 0) idle();
            else if (op == 1) rd(a);
            else begin
                case (a & 7)
                    1: wr(a, $urandom_range(0, 15));
                    2: wr(a, $urandom_range(1, 40));
                    3: wr(a, 0);
                    6: wr(a, $urandom_range(0, 3));
                    default: wr(a, $urandom);
                endcase
            end
        end

        // reset in the middle of counting
        wr(2, 30);
        wr(1, 7);
        repeat (5) idle();
        #3 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("irq_midreset", int'(irq), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        model_step(0, 0, 0);
        rdk(0, 16'h0000);
        rdk(2, 16'h0018);
        rdk(1, 16'h0000);
        idle();
        idle();
        check("queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
